// File: rtl/sar_search_ctrl_if.sv
// Comparator bus between the SAR search controller and an n-bit comparator.
// The controller drives operand b (trial); the comparator returns its flags.
interface sar_search_ctrl_if #(
    parameter int n = 32
);
    logic [n-1:0] trial;
    logic         lesser;
    logic         greater;
    logic         equal;

    modport master (output trial, input lesser, input greater, input equal);
    modport slave  (input trial, output lesser, output greater, output equal);
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: resolves an unknown target
// MSB-first by probing an external magnitude comparator, one bit per probe.
module sar_search_ctrl #(
    parameter int n   = 32,
    parameter int LAT = 0,
    localparam int SW = $clog2(n + 1),
    localparam int IW = (n > 1) ? $clog2(n) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    sar_search_ctrl_if.master        cmp,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [n-1:0]             result_o,
    output logic                     found_o,
    output logic                     err_o,
    output logic [SW-1:0]            steps_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TEST,
        S_DONE
    } state_t;

    localparam logic [n-1:0] ONE = n'(1);
    localparam logic [n-1:0] TOP = ONE << (n - 1);
    localparam logic [3:0]   WL  = 4'(LAT);
    localparam logic [IW-1:0] MSB_IDX = IW'(n - 1);

    state_t          state_q, state_d;
    logic [n-1:0]    acc_q, acc_d;
    logic [IW-1:0]   bit_idx_q, bit_idx_d;
    logic [3:0]      wait_q, wait_d;
    logic [n-1:0]    trial_q, trial_d;
    logic [n-1:0]    result_q, result_d;
    logic [SW-1:0]   steps_q, steps_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            found_q, found_d;
    logic            err_q, err_d;

    logic [2:0]      flags;
    logic            one_hot;
    logic [n-1:0]    acc_nx;
    logic [IW-1:0]   idx_nx;

    assign flags   = {cmp.lesser, cmp.greater, cmp.equal};
    assign one_hot = (flags == 3'b100) || (flags == 3'b010) ||
                     (flags == 3'b001);

    // State and datapath registers; reset aborts any search silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            bit_idx_q <= '0;
            wait_q    <= '0;
            trial_q   <= '0;
            result_q  <= '0;
            steps_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_idx_q <= bit_idx_d;
            wait_q    <= wait_d;
            trial_q   <= trial_d;
            result_q  <= result_d;
            steps_q   <= steps_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            err_q     <= err_d;
        end
    end

    // Next-state: accept start, settle LAT cycles, then sample and narrow.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_idx_d = bit_idx_q;
        wait_d    = wait_q;
        trial_d   = trial_q;
        result_d  = result_q;
        steps_d   = steps_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        found_d   = found_q;
        err_d     = err_q;
        acc_nx    = acc_q;
        idx_nx    = bit_idx_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d     = '0;
                    bit_idx_d = MSB_IDX;
                    trial_d   = TOP;
                    steps_d   = '0;
                    busy_d    = 1'b1;
                    found_d   = 1'b0;
                    err_d     = 1'b0;
                    wait_d    = WL;
                    state_d   = (LAT > 0) ? S_WAIT : S_TEST;
                end
            end
            S_WAIT: begin
                if (wait_q <= 4'd1) begin
                    state_d = S_TEST;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_TEST: begin
                steps_d = steps_q + 1'b1;
                if (!one_hot) begin
                    // Ambiguous flags: report what was resolved so far.
                    err_d    = 1'b1;
                    result_d = acc_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (cmp.equal) begin
                    result_d = trial_q;
                    found_d  = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    if (cmp.greater) begin
                        acc_nx = trial_q;
                    end
                    acc_d = acc_nx;
                    if (bit_idx_q == '0) begin
                        result_d = acc_nx;
                        found_d  = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        idx_nx    = bit_idx_q - 1'b1;
                        bit_idx_d = idx_nx;
                        trial_d   = acc_nx | (ONE << idx_nx);
                        wait_d    = WL;
                        state_d   = (LAT > 0) ? S_WAIT : S_TEST;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmp.trial = trial_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign found_o   = found_q;
    assign err_o     = err_q;
    assign steps_o   = steps_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: two instances (LAT=0, LAT=2) against a modelled
// comparator; a scoreboard queue is checked by a done-driven monitor.
module tb_sar_search_ctrl;

    localparam int N  = 8;
    localparam int SW = 4;

    typedef struct {
        int           id;
        logic [N-1:0] res;
        logic         found;
        logic         err;
        logic [SW-1:0] steps;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic [N-1:0] tgt0 = '0;
    logic [N-1:0] tgt1 = '0;
    logic         frc_en = 1'b0;
    logic [2:0]   frc_val = 3'b000;
    logic [N-1:0] frc_trial = '0;

    always #5 clk = ~clk;

    sar_search_ctrl_if #(.n(N)) c0 ();
    sar_search_ctrl_if #(.n(N)) c1 ();

    logic          bz [2];
    logic          dn [2];
    logic          fd [2];
    logic          er [2];
    logic [N-1:0]  rs [2];
    logic [N-1:0]  tr [2];
    logic [SW-1:0] st [2];

    sar_search_ctrl #(.n(N), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .cmp(c0),
        .busy_o(bz[0]), .done_o(dn[0]), .result_o(rs[0]),
        .found_o(fd[0]), .err_o(er[0]), .steps_o(st[0])
    );

    sar_search_ctrl #(.n(N), .LAT(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .cmp(c1),
        .busy_o(bz[1]), .done_o(dn[1]), .result_o(rs[1]),
        .found_o(fd[1]), .err_o(er[1]), .steps_o(st[1])
    );

    assign tr[0] = c0.trial;
    assign tr[1] = c1.trial;

    // Comparator models; instance 0 can be forced to bad flags on one trial.
    always_comb begin
        c0.lesser  = tgt0 < c0.trial;
        c0.greater = tgt0 > c0.trial;
        c0.equal   = tgt0 == c0.trial;
        if (frc_en && c0.trial == frc_trial)
            {c0.lesser, c0.greater, c0.equal} = frc_val;
        c1.lesser  = tgt1 < c1.trial;
        c1.greater = tgt1 > c1.trial;
        c1.equal   = tgt1 == c1.trial;
    end

    int n_cmp = 0;
    int n_bad = 0;
    exp_t sbq[$];
    logic [N-1:0] prq[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    logic         pbz [2] = '{1'b0, 1'b0};
    logic [N-1:0] ptr [2];
    int           cyc [2] = '{0, 0};
    exp_t         ex;
    logic [N-1:0] ep;

    // Monitor: checks each new probe value and every done pulse.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (bz[k]) begin
                if ((!pbz[k] || tr[k] != ptr[k]) && prq.size() > 0) begin
                    ep = prq.pop_front();
                    chk("probe", 32'(tr[k]), 32'(ep));
                end
                cyc[k] = pbz[k] ? cyc[k] + 1 : 1;
            end
            if (dn[k]) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: dut %0d res %0h", k, rs[k]);
                end else begin
                    ex = sbq.pop_front();
                    chk("dut_id", 32'(k), 32'(ex.id));
                    chk("result", 32'(rs[k]), 32'(ex.res));
                    chk("found", 32'(fd[k]), 32'(ex.found));
                    chk("err", 32'(er[k]), 32'(ex.err));
                    chk("steps", 32'(st[k]), 32'(ex.steps));
                    chk("latency", 32'(cyc[k]), 32'(ex.cyc));
                    chk("busy_at_done", 32'(bz[k]), 32'd0);
                end
            end
            pbz[k] = bz[k];
            ptr[k] = tr[k];
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 300 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: %0d results outstanding", sbq.size());
            sbq.delete();
            prq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go(int k, logic [N-1:0] t, logic [N-1:0] r, logic f,
                      logic e, logic [SW-1:0] s, int cy, int poke);
        exp_t x;
        x = '{k, r, f, e, s, cy};
        sbq.push_back(x);
        if (k == 0) begin tgt0 = t; start0 = 1'b1; end
        else begin tgt1 = t; start1 = 1'b1; end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1;
            if (k == 0) start0 = 1'b1; else start1 = 1'b1;
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
        end
        wait_done();
        chk("hold_result", 32'(rs[k]), 32'(r));
        chk("done_one_cycle", 32'(dn[k]), 32'd0);
    endtask

    task automatic chk_zero(int k, string nm);
        chk({nm, "_trial"}, 32'(tr[k]), 32'd0);
        chk({nm, "_busy"}, 32'(bz[k]), 32'd0);
        chk({nm, "_done"}, 32'(dn[k]), 32'd0);
        chk({nm, "_result"}, 32'(rs[k]), 32'd0);
        chk({nm, "_found"}, 32'(fd[k]), 32'd0);
        chk({nm, "_err"}, 32'(er[k]), 32'd0);
        chk({nm, "_steps"}, 32'(st[k]), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");

        prq = {8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
        go(0, 8'h5A, 8'h5A, 1'b1, 1'b0, 4'd7, 7, 0);
        prq = {8'h80};
        go(0, 8'h80, 8'h80, 1'b1, 1'b0, 4'd1, 1, 0);
        prq = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        go(0, 8'h00, 8'h00, 1'b0, 1'b0, 4'd8, 8, 0);
        prq = {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        go(0, 8'hFF, 8'hFF, 1'b1, 1'b0, 4'd8, 8, 0);
        // start while busy, then start during the done cycle
        go(0, 8'h5A, 8'h5A, 1'b1, 1'b0, 4'd7, 7, 2);
        go(0, 8'h33, 8'h33, 1'b1, 1'b0, 4'd8, 8, 7);

        prq = {8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
        go(1, 8'hFF, 8'hFF, 1'b1, 1'b0, 4'd8, 24, 0);
        prq = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        go(1, 8'h00, 8'h00, 1'b0, 1'b0, 4'd8, 24, 0);
        go(1, 8'h80, 8'h80, 1'b1, 1'b0, 4'd1, 3, 0);
        go(1, 8'h5A, 8'h5A, 1'b1, 1'b0, 4'd7, 21, 4);

        frc_en = 1'b1;
        frc_trial = 8'h60;
        frc_val = 3'b000;
        prq = {8'h80, 8'h40, 8'h60};
        go(0, 8'h5A, 8'h40, 1'b0, 1'b1, 4'd3, 3, 0);
        frc_val = 3'b110;
        prq = {8'h80, 8'h40, 8'h60};
        go(0, 8'h5A, 8'h40, 1'b0, 1'b1, 4'd3, 3, 0);
        frc_en = 1'b0;
        go(0, 8'h80, 8'h80, 1'b1, 1'b0, 4'd1, 1, 0);

        // reset in the middle of a search: no done, everything cleared
        tgt0 = 8'h00;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(bz[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero(0, "abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk_zero(0, "post_abort");
        prq = {8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
        go(0, 8'h5A, 8'h5A, 1'b1, 1'b0, 4'd7, 7, 3);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller: the initiator side of the n-bit magnitude comparator interface.
- Drives the comparator's b operand (`trial`) and reads back its lesser/greater/equal flags. The comparator's a operand is wired to an external, unknown target held static during a search.
- Resolves the target MSB-first, at one comparison per probe, and reports the recovered value, the probe count, and a protocol-error flag.
- Used for threshold discovery and calibration loops around the existing comparator.

Parameters:
- n, 32, operand width; must equal the attached comparator's n.
- LAT, 0, extra settle cycles between driving `trial` and sampling flags (0..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- lesser  input  1  comparator flag: target < trial.
- greater  input  1  comparator flag: target > trial.
- equal  input  1  comparator flag: target == trial.
- trial  output  n  probe value driven to comparator b.
- busy  output  1  high from the start-accept edge until done.
- done  output  1  one-cycle pulse; result, found, steps and err are valid from this cycle on.
- result  output  n  recovered target value.
- found  output  1  search terminated on an equal flag.
- err  output  1  flags were not one-hot when sampled.
- steps  output  $clog2(n+1)  number of TEST samples taken.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; trial, result, steps = 0; busy, done, found, err = 0.
- Internal state: acc[n-1:0], bit_idx, wait_cnt.
- IDLE:
  - start=1 → acc=0, bit_idx=n-1, trial=1<<(n-1), steps=0, busy=1.
  - found, err and done clear on this edge.
  - Go to WAIT if LAT>0, else TEST.
- WAIT: wait_cnt loaded with LAT, decrements each cycle; at 1 → TEST. Each probe therefore occupies LAT+1 cycles.
- TEST (flags sampled on this edge; steps increments):
  - Flags not exactly one-hot → err=1, result=acc, → DONE.
  - equal → result=trial, found=1, → DONE.
  - greater → acc=trial (bit kept).
  - lesser → acc unchanged (bit dropped).
  - bit_idx==0 → result=updated acc, found=0, → DONE.
  - Otherwise bit_idx-1, trial=updated acc | (1<<(bit_idx-1)), → WAIT/TEST.
- DONE:
  - done=1 for exactly one cycle; busy=0 on the same edge; → IDLE.
  - result, found, err and steps hold until the next accepted start.
- trial keeps its last value in DONE/IDLE; it is not cleared.
- Latency: probes × (LAT+1) cycles from the start-accept edge to done high. Maximum is n × (LAT+1).
- found=0 without err occurs only when the target is 0 (a zero trial is never issued); result=0 in that case.
- start while busy or done is ignored; no queuing.
- Reset mid-search aborts immediately to reset values; no done pulse is issued.
- Flags are consumed only in TEST; their values in WAIT/IDLE are don't-care.

Test Plan:
- n=8, LAT=0, target=0x5A, start pulse → trial 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A on consecutive cycles; done at cycle 7; result=0x5A, found=1, steps=7, err=0.
- n=8, target=0x80 → first probe equal; done after 1 cycle; result=0x80, found=1, steps=1.
- n=8, target=0x00 → trials 0x80..0x01 all lesser; done after 8 cycles; result=0x00, found=0, steps=8, err=0.
- n=8, LAT=2, target=0xFF → trials 0x80,0xC0,…,0xFF held 3 cycles each; done at cycle 24; result=0xFF, found=1, steps=8.
- Force flags 000 (and separately 110) at the third TEST → err=1, done pulse, result=partial acc, steps=3.
- Assert rst_n=0 mid-search, then re-release, and pulse start during busy → all outputs reset with no done; start during busy is ignored; a new start after reset completes normally.
